// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between CPU port A and streaming port B
// with round-robin arbitration, bounded burst lock and per-port read-valid steering.
module ram_arbiter #(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic        a_lock,
  input  logic [14:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic        b_lock,
  input  logic [14:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [7:0]  b_rdata,
  output logic [14:0] ram_addr,
  output logic [7:0]  ram_data_in,
  output logic        ram_write_enable,
  input  logic [7:0]  ram_data_out
);
  localparam logic [7:0] LP_MAX = 8'(MAX_LOCK);
  typedef enum logic [1:0] {S_ARB, S_LOCK_A, S_LOCK_B} state_t;
  state_t     r_state, w_state_nx;
  logic       r_ptr, w_ptr_nx;
  logic [7:0] r_cnt, w_cnt_nx;
  logic       r_a_rvalid, r_b_rvalid;
  logic       w_lock, w_own, w_own_req, w_oth_req, w_own_lock;
  logic       w_force, w_keep, w_arb_b, w_sel_b, w_sel_lock, w_gnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_ARB;
      r_ptr      <= 1'b1;
      r_cnt      <= 8'd0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_ptr      <= w_ptr_nx;
      r_cnt      <= w_cnt_nx;
      r_a_rvalid <= a_gnt & ~a_we;
      r_b_rvalid <= b_gnt & ~b_we;
    end
  end
  // w_own: 1 when B holds the lock; w_force hands one access to the waiting port
  assign w_lock     = r_state != S_ARB;
  assign w_own      = r_state == S_LOCK_B;
  assign w_own_req  = w_own ? b_req : a_req;
  assign w_oth_req  = w_own ? a_req : b_req;
  assign w_own_lock = w_own ? b_lock : a_lock;
  assign w_force    = w_lock & w_own_req & w_oth_req & (r_cnt >= LP_MAX);
  assign w_keep     = w_lock & w_own_req & ~w_force;
  assign w_arb_b    = b_req & (~a_req | ~r_ptr);
  assign w_sel_b    = w_force ? ~w_own : w_keep ? w_own : w_arb_b;
  assign w_sel_lock = w_sel_b ? b_lock : a_lock;
  assign w_gnt      = ~reset & (a_req | b_req);
  always_comb begin
    w_state_nx = S_ARB;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    if (w_gnt) begin
      w_ptr_nx = w_sel_b;
      if (w_keep & w_own_lock) begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 8'(r_cnt != 8'hFF);
      end else if (~w_force & ~w_keep & w_sel_lock) begin
        w_state_nx = w_sel_b ? S_LOCK_B : S_LOCK_A;
        w_cnt_nx   = 8'd1;
      end
    end
  end
  always_comb begin
    a_gnt            = w_gnt & ~w_sel_b;
    b_gnt            = w_gnt & w_sel_b;
    ram_addr         = b_gnt ? b_addr : a_addr;
    ram_data_in      = b_gnt ? b_wdata : a_wdata;
    ram_write_enable = (a_gnt & a_we) | (b_gnt & b_we);
    a_rvalid         = r_a_rvalid & ~reset;
    b_rvalid         = r_b_rvalid & ~reset;
    a_rdata          = ram_data_out;
    b_rdata          = ram_data_out;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: random two-port traffic checked against a port-level reference model.
module tb_ram_arbiter;
  localparam int ML = 4;
  localparam int NCYC = 4000;
  logic clk = 1'b0;
  logic reset;
  logic a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [14:0] a_addr, b_addr, ram_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_data_in, ram_data_out;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, ram_write_enable;
  int n_chk = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  ram_arbiter #(.MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
  );
  logic [7:0] mem [0:32767];
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  bit p_act[2], p_we[2], p_lock[2];
  logic [14:0] p_addr[2];
  logic [7:0] p_wd[2];
  logic [7:0] sh [0:32767];
  bit kn [0:32767];
  int m_owner, m_held, m_last, w, o, phase, cur_rv, nxt_rv;
  int wait_c[2];
  bit rst, cur_kn;
  logic [7:0] cur_rd;
  initial begin
    for (int i = 0; i < 32768; i++) kn[i] = 1'b0;
    m_owner = -1; m_held = 0; m_last = 1; cur_rv = -1; cur_kn = 0; cur_rd = 8'h0;
    wait_c[0] = 0; wait_c[1] = 0;
    for (int p = 0; p < 2; p++) p_act[p] = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      phase = cyc / 1000;
      rst = (cyc < 3) || (phase == 3 && $urandom_range(0, 49) == 0);
      for (int p = 0; p < 2; p++) begin
        int prob, lk;
        prob = (phase == 2) ? (p == 1 ? 100 : 0) : (phase == 1 && p == 1) ? 100 : 60;
        lk = (phase == 1 || phase == 2) && p == 1 ? 100 : (phase == 3 ? 50 : 30);
        if (!p_act[p] && $urandom_range(0, 99) < prob) begin
          p_act[p]  = 1;
          p_we[p]   = $urandom_range(0, 2) == 0;
          p_lock[p] = $urandom_range(0, 99) < lk;
          p_addr[p] = 15'($urandom_range(0, 7)) + ($urandom_range(0, 1) ? 15'h7FF8 : 15'h1230);
          p_wd[p]   = 8'($urandom);
        end
      end
      reset = rst;
      a_req = p_act[0]; a_we = p_we[0]; a_lock = p_lock[0]; a_addr = p_addr[0]; a_wdata = p_wd[0];
      b_req = p_act[1]; b_we = p_we[1]; b_lock = p_lock[1]; b_addr = p_addr[1]; b_wdata = p_wd[1];
      #1;
      w = -1;
      if (rst) begin
        m_owner = -1; m_last = 1;
      end else if (p_act[0] || p_act[1]) begin
        if (m_owner >= 0 && p_act[m_owner]) begin
          o = m_owner;
          if (m_held >= ML && p_act[1-o]) begin
            w = 1 - o; m_owner = -1;
          end else begin
            w = o;
            if (p_lock[o]) m_held++;
            else m_owner = -1;
          end
        end else begin
          m_owner = -1;
          w = (p_act[0] && p_act[1]) ? 1 - m_last : (p_act[0] ? 0 : 1);
          if (p_lock[w]) begin m_owner = w; m_held = 1; end
        end
        m_last = w;
      end else m_owner = -1;
      chk("a_gnt", 32'(a_gnt), 32'(w == 0));
      chk("b_gnt", 32'(b_gnt), 32'(w == 1));
      chk("ram_we", 32'(ram_write_enable), 32'(w >= 0 && p_we[w]));
      chk("ram_addr", 32'(ram_addr), 32'(w == 1 ? p_addr[1] : p_addr[0]));
      if (w >= 0 && p_we[w]) chk("ram_wdata", 32'(ram_data_in), 32'(p_wd[w]));
      chk("a_rvalid", 32'(a_rvalid), 32'(cur_rv == 0 && !rst));
      chk("b_rvalid", 32'(b_rvalid), 32'(cur_rv == 1 && !rst));
      if (cur_rv >= 0 && !rst && cur_kn)
        chk("rdata", 32'(cur_rv == 0 ? a_rdata : b_rdata), 32'(cur_rd));
      for (int p = 0; p < 2; p++) begin
        wait_c[p] = (p_act[p] && w != p && !rst) ? wait_c[p] + 1 : 0;
        chk("starve", 32'(wait_c[p] > ML + 1), 32'd0);
      end
      nxt_rv = -1;
      if (w >= 0) begin
        if (p_we[w]) begin
          sh[p_addr[w]] = p_wd[w]; kn[p_addr[w]] = 1;
        end else begin
          nxt_rv = w; cur_rd = sh[p_addr[w]]; cur_kn = kn[p_addr[w]];
        end
        p_act[w] = 0;
      end
      cur_rv = nxt_rv;
      @(posedge clk);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
